// File: rtl/alu_control_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_control_muldiv_pkg
//  Purpose  : Shared constants for the execute-stage ALU control and the
//             iterative multiply/divide sequencer: ALU select codes, LEGv8
//             opcode/shamt patterns, sequencer state encodings, the latched
//             operation type and the combinational alu_op/opcode decode.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_control_muldiv_pkg;

  // Single-cycle ALU select codes. The bit-pattern R-type codes
  // (AND/ORR/ADD/SUB) come straight out of the opcode bits and need no names.
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_PASS_B = 4'b0111;
  localparam logic [3:0] ALU_MUL    = 4'b1000;
  localparam logic [3:0] ALU_SDIV   = 4'b1010;
  localparam logic [3:0] ALU_UDIV   = 4'b1011;

  // instruction[31:21] patterns
  localparam logic [10:0] OP_MUL = 11'b10011011000;
  localparam logic [10:0] OP_DIV = 11'b10011010110;

  // instruction[15:10] selects signed vs unsigned divide
  localparam logic [5:0] FN_SDIV = 6'b000010;
  localparam logic [5:0] FN_UDIV = 6'b000011;

  // Sequencer states
  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  // Operation captured at accept
  typedef enum logic [1:0] {
    MD_OP_MUL  = 2'd0,
    MD_OP_UDIV = 2'd1,
    MD_OP_SDIV = 2'd2
  } md_op_e;

  // alu_op/opcode/shamt -> ALU select. The generic R-type path always has a
  // zero MSB, so bit 3 of the result is set only for MUL/SDIV/UDIV.
  function automatic logic [3:0] alu_decode(input logic [1:0]  alu_op,
                                            input logic [10:0] opcode,
                                            input logic [5:0]  shamt);
    logic [3:0] ctl;
    ctl = ALU_ADD;
    if (alu_op == 2'b00) begin
      ctl = ALU_ADD;
    end else if (alu_op == 2'b01) begin
      ctl = ALU_PASS_B;
    end else if (opcode == OP_MUL) begin
      ctl = ALU_MUL;
    end else if ((opcode == OP_DIV) && (shamt == FN_SDIV)) begin
      ctl = ALU_SDIV;
    end else if ((opcode == OP_DIV) && (shamt == FN_UDIV)) begin
      ctl = ALU_UDIV;
    end else begin
      ctl = {1'b0, opcode[9], opcode[3], opcode[8]};
    end
    return ctl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_step
//  Purpose  : One combinational iteration of the multiply/divide datapath.
//             MUL  : shift-add, LSB first. acc = partial product,
//                    x = multiplicand (shifts left), y = multiplier (shifts right).
//             DIV  : restoring divide. acc = partial remainder, x = divisor,
//                    y = dividend bits shifting out MSB-first while quotient
//                    bits shift in at the LSB.
//  Ports    : i_is_div        - select divide step (else multiply step)
//             i_acc/i_x/i_y   - working registers in
//             o_acc/o_x/o_y   - working registers after one step
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int DATA_W = 64
) (
  input  logic              i_is_div,
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  output logic [DATA_W-1:0] o_acc,
  output logic [DATA_W-1:0] o_x,
  output logic [DATA_W-1:0] o_y
);

  // Remainder is always < divisor, so after shifting in one dividend bit it
  // needs one extra bit; the trial subtraction's MSB is then a clean borrow.
  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;

  assign w_shift = {i_acc, i_y[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, i_x};

  always_comb begin
    o_acc = i_acc;
    o_x   = i_x;
    o_y   = i_y;
    if (i_is_div) begin
      if (!w_diff[DATA_W]) begin
        o_acc = w_diff[DATA_W-1:0];
        o_y   = {i_y[DATA_W-2:0], 1'b1};
      end else begin
        o_acc = w_shift[DATA_W-1:0];
        o_y   = {i_y[DATA_W-2:0], 1'b0};
      end
    end else begin
      o_acc = i_acc + (i_y[0] ? i_x : '0);
      o_x   = i_x << 1;
      o_y   = i_y >> 1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_control_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : alu_control_muldiv
//  Purpose  : Execute-stage ALU control decode plus an iterative MUL/SDIV/UDIV
//             sequencer that stalls the pipeline while it runs.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             alu_op/opcode/shamt - instruction decode inputs
//             start           - execute stage holds a valid instruction
//             flush           - squash the in-flight operation
//             a, b            - operands Rn, Rm
//             alu_control     - single-cycle ALU select (combinational)
//             is_muldiv       - instruction is MUL/SDIV/UDIV (combinational)
//             stall           - hold PC and IF/ID/EX state
//             done            - one-cycle pulse, result valid
//             result          - mul/div result
//  Params   : DATA_W          - operand width
//             BITS_PER_CYCLE  - iterations per cycle (1, 2 or 4; divides DATA_W)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_control_muldiv
  import alu_control_muldiv_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        alu_op,
  input  logic [10:0]       opcode,
  input  logic [5:0]        shamt,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [3:0]        alu_control,
  output logic              is_muldiv,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int c_ITERS = DATA_W / BITS_PER_CYCLE;
  localparam int c_CNT_W = $clog2(c_ITERS + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_ITERS);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_count;
  md_op_e             r_op;
  logic               r_neg_q;
  logic               r_div0;
  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_x;
  logic [DATA_W-1:0]  r_y;
  logic [DATA_W-1:0]  r_result;

  logic [3:0]        w_alu_control;
  logic              w_is_muldiv;
  logic              w_accept;
  logic              w_sdiv;
  logic              w_mul_in;
  logic              w_is_div;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] w_fixed;

  // ---------------------------------------------------------------- decode
  assign w_alu_control = alu_decode(alu_op, opcode, shamt);
  assign w_is_muldiv   = w_alu_control[3];
  assign alu_control   = w_alu_control;
  assign is_muldiv     = w_is_muldiv;

  assign w_sdiv   = (w_alu_control == ALU_SDIV);
  assign w_mul_in = (w_alu_control == ALU_MUL);
  assign w_accept = (r_state == MD_IDLE) && start && w_is_muldiv && !flush;

  // The stall asserts in the accept cycle itself so the instruction is held
  // in EX from the very first cycle; it drops in DONE so the pipeline can
  // advance while the result is consumed.
  assign stall  = w_accept || (r_state == MD_CALC) || (r_state == MD_FIX);
  assign done   = (r_state == MD_DONE);
  assign result = r_result;

  // Signed divide runs on magnitudes; MIN stays MIN, which as an unsigned
  // value is exactly |MIN|, so MIN / -1 wraps back to MIN with no special case.
  assign w_a_mag = (w_sdiv && a[DATA_W-1]) ? (-a) : a;
  assign w_b_mag = (w_sdiv && b[DATA_W-1]) ? (-b) : b;

  // ------------------------------------------------------------ step chain
  assign w_is_div = (r_op != MD_OP_MUL);

  logic [DATA_W-1:0] w_acc [0:BITS_PER_CYCLE];
  logic [DATA_W-1:0] w_x   [0:BITS_PER_CYCLE];
  logic [DATA_W-1:0] w_y   [0:BITS_PER_CYCLE];

  assign w_acc[0] = r_acc;
  assign w_x[0]   = r_x;
  assign w_y[0]   = r_y;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      muldiv_step #(
        .DATA_W (DATA_W)
      ) u_step (
        .i_is_div (w_is_div),
        .i_acc    (w_acc[gi]),
        .i_x      (w_x[gi]),
        .i_y      (w_y[gi]),
        .o_acc    (w_acc[gi+1]),
        .o_x      (w_x[gi+1]),
        .o_y      (w_y[gi+1])
      );
    end
  endgenerate

  // ------------------------------------------------------------- fix-up
  // The raw restoring loop yields all-ones for a zero divisor; the quotient
  // is forced to zero instead.
  assign w_q     = !w_is_div ? r_acc : (r_div0 ? '0 : r_y);
  assign w_fixed = r_neg_q ? (-w_q) : w_q;

  // ------------------------------------------------------------ sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= MD_IDLE;
      r_count  <= '0;
      r_op     <= MD_OP_MUL;
      r_neg_q  <= 1'b0;
      r_div0   <= 1'b0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            r_op    <= w_mul_in ? MD_OP_MUL : (w_sdiv ? MD_OP_SDIV : MD_OP_UDIV);
            r_neg_q <= w_sdiv && (a[DATA_W-1] ^ b[DATA_W-1]);
            r_div0  <= !w_mul_in && (b == '0);
            r_acc   <= '0;
            r_x     <= w_mul_in ? a : w_b_mag;
            r_y     <= w_mul_in ? b : w_a_mag;
            r_count <= c_CNT_LOAD;
            r_state <= MD_CALC;
          end
        end
        MD_CALC: begin
          if (flush) begin
            r_state <= MD_IDLE;
          end else begin
            r_acc   <= w_acc[BITS_PER_CYCLE];
            r_x     <= w_x[BITS_PER_CYCLE];
            r_y     <= w_y[BITS_PER_CYCLE];
            r_count <= r_count - 1'b1;
            if (r_count == c_CNT_LAST) begin
              r_state <= MD_FIX;
            end
          end
        end
        MD_FIX: begin
          if (flush) begin
            r_state <= MD_IDLE;
          end else begin
            r_result <= w_fixed;
            r_state  <= MD_DONE;
          end
        end
        MD_DONE: begin
          r_state <= MD_IDLE;
        end
        default: begin
          r_state <= MD_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_control_muldiv.md
Name: alu_control_muldiv

Overview:
- Next-generation ALU control for the execute stage.
- Retains the combinational alu_op/opcode-to-alu_control decode.
- Adds a parametrised iterative multiply/divide sequencer for LEGv8 MUL, SDIV and UDIV, with a start/stall/done handshake that freezes the pipeline while the operation runs.
- The result is muxed into the execute-stage writeback path alongside the single-cycle ALU result.

Parameters:
- DATA_W, 64: operand and result width.
- BITS_PER_CYCLE, 1: iteration bits retired per cycle. Legal values are 1, 2 and 4, and the value must divide DATA_W. N = DATA_W/BITS_PER_CYCLE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- alu_op  in  2  main-control ALU class.
- opcode  in  11  instruction[31:21].
- shamt  in  6  instruction[15:10]. Distinguishes SDIV (000010) from UDIV (000011).
- start  in  1  execute stage holds a valid instruction this cycle.
- flush  in  1  squash the in-flight operation.
- a  in  DATA_W  operand Rn.
- b  in  DATA_W  operand Rm.
- alu_control  out  4  single-cycle ALU select (combinational).
- is_muldiv  out  1  current instruction is MUL, SDIV or UDIV (combinational).
- stall  out  1  hold PC and IF/ID/EX state.
- done  out  1  one-cycle pulse; result valid.
- result  out  DATA_W  mul/div result.

Behaviour:
- Decode (combinational):
  - alu_op 00 gives ALU_ADD.
  - alu_op 01 gives ALU_PASS_B.
  - alu_op 1x with opcode 10011011000 gives ALU_MUL.
  - alu_op 1x with opcode 10011010110 and shamt 000010 gives ALU_SDIV.
  - alu_op 1x with opcode 10011010110 and shamt 000011 gives ALU_UDIV.
  - Any other alu_op 1x gives {1'b0, opcode[9], opcode[3], opcode[8]}.
  - is_muldiv = 1 for the three mul/div codes only.
- Accept: in IDLE with start & is_muldiv & !flush.
  - Latch operands and op.
  - SDIV: latch magnitudes |a| and |b| as unsigned DATA_W values, plus neg_q = a[MSB]^b[MSB].
  - Load counter with N. Go to CALC.
- FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
  - CALC: run N cycles, BITS_PER_CYCLE steps per cycle, counter decrements each cycle.
    - MUL: shift-add; keep the low DATA_W bits (signedness irrelevant).
    - UDIV/SDIV: restoring division on the unsigned magnitudes, quotient only.
  - FIX: SDIV with neg_q set negates the quotient (two's complement). Otherwise pass through. Write result.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Latency: an accept in cycle 0 gives done in cycle N+2 (66 for defaults).
- Stall (combinational): stall = (IDLE & start & is_muldiv & !flush) | CALC | FIX.
  - Stall is low in DONE, so the pipeline advances in the same cycle result is consumed.
- Divide by zero: quotient = 0 for both SDIV and UDIV. Full latency is kept; there is no early exit.
- SDIV overflow: MIN / -1 = MIN (wraps naturally via magnitude arithmetic).
- Result stability: result holds its value from DONE until the FIX cycle of the next accepted operation.
- start in CALC/FIX/DONE: ignored, no re-accept.
  - The pipeline re-presents the same instruction after done only if it has not advanced. Control guarantees it has advanced.
- flush:
  - In CALC/FIX: go to IDLE next cycle. No done. stall drops the cycle after flush. result is unchanged.
  - In IDLE: flush wins over a simultaneous start.
  - In DONE: done still pulses this cycle.
- Reset values (sync, any state): state = IDLE, counter = 0, result = 0, done = 0, stall = 0, internal registers = 0.
  - Reset mid-operation aborts with no done.
- Non-muldiv instructions: no effect on the FSM. stall stays 0.

Decomposition:
- constants.vh gains ALU_MUL = 4'b1000, ALU_SDIV = 4'b1010 and ALU_UDIV = 4'b1011, alongside the existing ALU_* codes.
- constants.vh also gains opcode constants OP_MUL and OP_DIV, shamt constants FN_SDIV and FN_UDIV, and state encodings MD_IDLE, MD_CALC, MD_FIX and MD_DONE.
- One sub-module, muldiv_step: a combinational single-iteration step (shift-add or restore) instanced BITS_PER_CYCLE times in a chain.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD), start for one cycle:
  - stall is high in cycles 0..65.
  - done is high in cycle 66 only.
  - result = 0xFFFF_FFFF_FFFF_FFEB (-21).
- UDIV a=100, b=7 gives result 14. SDIV a=-100, b=7 gives result -14 (0xFFFF_FFFF_FFFF_FFF2). SDIV a=100, b=-7 gives result -14.
- UDIV by zero, a=5, b=0: result 0 with done at cycle 66. SDIV 0x8000_0000_0000_0000 / -1: result 0x8000_0000_0000_0000.
- Decode sweep:
  - alu_op 00 gives ADD; alu_op 01 gives PASS_B.
  - ADD/SUB/AND/ORR R-type opcodes give 0010, 0110, 0000 and 0001 respectively.
  - MUL, SDIV and UDIV give 1000, 1010 and 1011 respectively.
  - stall stays 0 for all non-muldiv instructions.
- Abort cases:
  - flush at cycle 10 of a MUL: IDLE at cycle 11, stall 0 at cycle 11, no done, result unchanged.
  - reset at cycle 20: identical outcome, with result = 0.
  - A new MUL issued afterwards completes correctly.
- Back-to-back: a second start held during busy is ignored; a new start in the cycle after done is accepted. With BITS_PER_CYCLE = 4, MUL 0x1234 × 0x10 gives 0x12340 with done at cycle 18.
